// File: rtl/div_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock, with signed and unsigned modes.
// Divide-by-zero and signed overflow skip the iteration and complete on the accept edge.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  is_signed_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rmd_q, rmd_d;
  logic                  dbz_q, dbz_d;

  logic                  a_neg, b_neg, is_ovf, q_bit;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, rem_next, quo_next;
  logic [DATA_WIDTH:0]   rem_shift, diff;

  assign a_neg  = is_signed_i & dividend_i[DATA_WIDTH-1];
  assign b_neg  = is_signed_i & divisor_i[DATA_WIDTH-1];
  assign a_mag  = a_neg ? -dividend_i : dividend_i;
  assign b_mag  = b_neg ? -divisor_i : divisor_i;
  assign is_ovf = is_signed_i && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) &&
                  (divisor_i == {DATA_WIDTH{1'b1}});

  // Extra top bit keeps the borrow of the trial subtraction.
  assign rem_shift = {rem_q, dvd_q[DATA_WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[DATA_WIDTH];
  assign rem_next  = q_bit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
  assign quo_next  = {dvd_q[DATA_WIDTH-2:0], q_bit};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (divisor_i == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rmd_d   = dividend_i;
            dbz_d   = 1'b1;
          end else if (is_ovf) begin
            state_d = StDone;
            quo_d   = dividend_i;
            rmd_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = StCalc;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            dbz_d   = 1'b0;
          end
        end
      end
      StCalc: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          state_d = StDone;
          quo_d   = negq_q ? -quo_next : quo_next;
          rmd_d   = negr_q ? -rem_next : rem_next;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands checked against an
// arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .is_signed_i  (is_signed),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output int lat);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; z = 1'b0; lat = 0;
    end else begin
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0; lat = 32;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  task automatic await_result(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input int hold);
    logic [31:0] eq, er;
    logic        ez;
    int          el, n;
    model(a, b, s, eq, er, ez, el);
    out_ready = (hold == 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL calc_in_ready: got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== el) begin
      errors++;
      $display("FAIL latency %h/%h s=%b: got %0d want %0d", a, b, s, n, el);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      errors++;
      $display("FAIL result %h/%h s=%b: got q=%h r=%h z=%b want q=%h r=%h z=%b",
               a, b, s, quotient, remainder, div_by_zero, eq, er, ez);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq || remainder !== er ||
          div_by_zero !== ez) begin
        errors++;
        $display("FAIL hold: got v=%b rdy=%b q=%h r=%h z=%b want v=1 rdy=0 q=%h r=%h z=%b",
                 out_valid, in_ready, quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy=%b v=%b q=%h r=%h z=%b want rdy=1 v=0 q=0 r=0 z=0",
               name, in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_zero("reset_state");
  endtask

  task automatic test_basic();
    issue(32'd100, 32'd7, 1'b0);
    await_result(32'd100, 32'd7, 1'b0, 0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    await_result(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    await_result(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    await_result(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
  endtask

  task automatic test_special();
    issue(32'd5, 32'd0, 1'b0);
    await_result(32'd5, 32'd0, 1'b0, 0);
    issue(32'd5, 32'd0, 1'b1);
    await_result(32'd5, 32'd0, 1'b1, 2);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    await_result(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    await_result(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    issue(32'd1000, 32'd33, 1'b0);
    // Next request held pending through CALC and DONE.
    dividend = 32'd77; divisor = 32'd5; is_signed = 1'b0; in_valid = 1'b1;
    await_result(32'd1000, 32'd33, 1'b0, 5);
    issue(32'd77, 32'd5, 1'b0);
    await_result(32'd77, 32'd5, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    issue(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("reset_mid_calc");
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abandoned_result: got v=%b want 0", out_valid);
      end
    end
    issue(32'd9, 32'd3, 1'b0);
    await_result(32'd9, 32'd3, 1'b0, 0);
    issue(32'd5, 32'd0, 1'b0);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    check_idle_zero("reset_in_done");
    in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    check_idle_zero("reset_over_accept");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      a = $urandom;
      s = 1'($urandom);
      case (sel)
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = $urandom_range(1, 15);
        3: b = 32'h8000_0000 | $urandom;
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      if (b == 32'd0 && sel != 0) b = 32'd1;
      issue(a, b, s);
      await_result(a, b, s, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits; all widths below refer to it.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request valid; operands and is_signed are valid while high.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 dividend  input  DATA_WIDTH  numerator.
REQ-007 divisor  input  DATA_WIDTH  denominator.
REQ-008 is_signed  input  1  1 = two's-complement division; 0 = unsigned division.
REQ-009 out_valid  output  1  quotient, remainder and div_by_zero are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DATA_WIDTH  result quotient.
REQ-012 remainder  output  DATA_WIDTH  result remainder.
REQ-013 div_by_zero  output  1  the current result came from divisor == 0.

Function
REQ-014 The unit SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-015 Accept SHALL occur on a rising edge where in_valid & in_ready; dividend, divisor and is_signed are captured at that edge only, and later input changes are ignored.
REQ-016 Normal case: at the accept edge, state goes IDLE->CALC; one restoring shift-subtract iteration runs per edge for exactly DATA_WIDTH edges; state goes CALC->DONE on the last iteration edge.
REQ-017 out_valid SHALL therefore rise exactly DATA_WIDTH cycles after the accept edge (32 for the default).
REQ-018 Signed mode: iterate on operand magnitudes; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); truncation toward zero.
REQ-019 Divisor == 0 (either mode): state goes IDLE->DONE at the accept edge; quotient = all ones; remainder = dividend; div_by_zero = 1; out_valid high 1 cycle after accept.
REQ-020 Signed overflow (dividend = most-negative, divisor = all ones, is_signed = 1): IDLE->DONE at the accept edge; quotient = dividend; remainder = 0; div_by_zero = 0.
REQ-021 In DONE, out_valid = 1 and quotient, remainder and div_by_zero SHALL hold stable until out_valid & out_ready.
REQ-022 DONE->IDLE on the out_valid & out_ready edge.
REQ-023 in_ready = 0 in DONE, so no accept occurs in the same cycle as result hand-off; the earliest next accept is the following cycle.
REQ-024 in_ready = 0 throughout CALC; requests presented in CALC or DONE stay pending (the requester holds in_valid).
REQ-025 out_valid = 0 in IDLE and CALC.
REQ-026 quotient and remainder outputs are don't-care while out_valid = 0 but SHALL be driven from registers; there are no combinational paths from inputs to outputs.
REQ-027 in_ready depends only on state and SHALL NOT depend on in_valid.
REQ-028 Internal partial-remainder arithmetic SHALL use DATA_WIDTH+1 bits so the trial subtraction never loses its borrow; unsigned divisors with the MSB set SHALL divide correctly.

Reset
REQ-029 While rst is high at a clock edge, state SHALL become IDLE and in_ready = 1 after that edge.
REQ-030 Reset values: out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, iteration counter = 0.
REQ-031 rst asserted mid-CALC or in DONE SHALL abandon the operation with no result ever presented.
REQ-032 rst SHALL take priority over a simultaneous accept or hand-off.

Verification
REQ-033 Unsigned 100 / 7, out_ready = 1 -> out_valid exactly 32 cycles after accept; quotient = 14, remainder = 2, div_by_zero = 0; IDLE next cycle.
REQ-034 Signed, dividend = 0xFFFFFFF9 (-7), divisor = 2 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1); unsigned 0xFFFFFFFF / 0x80000000 -> quotient = 1, remainder = 0x7FFFFFFF.
REQ-035 5 / 0 in both modes -> out_valid 1 cycle after accept; quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> out_valid 1 cycle after accept; quotient = 0x80000000, remainder = 0.
REQ-037 Back-pressure: out_ready held low for 5 cycles after out_valid -> outputs unchanged and in_ready = 0 throughout; hand-off occurs on the first out_ready = 1 edge; a back-to-back second request is accepted on the next cycle.
REQ-038 Reset mid-operation: rst pulsed for 1 cycle at iteration 10 -> the next cycle shows in_ready = 1, out_valid = 0 and all outputs = 0; a following 9 / 3 request gives quotient = 3, remainder = 0.
